pe_id_scan_loader: RTL and testbench

- Sequential consumer of the combinational PE-array ID generator outputs (filter/ifmap/ipsum/opsum XID/YID, LN_config).
- On `start`, snapshots all IDs, then shifts them beat-by-beat into the GIN/GON multicast-controller ID scan chains over a valid/ready config port.
- Sits in the Controller between the ID generator and the PE-array NoC; it is the writer side of the MC ID-programming interface.

---
 rtl/pe_id_scan_loader_if.sv | 24 ++
 rtl/pe_id_scan_loader.sv | 212 +++++++++++++++++++++
 tb/tb_pe_id_scan_loader.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_id_scan_loader_if.sv
// MC ID-programming config port: one beat carries either a YID or an XID
// shift for one of the four networks (0 filter, 1 ifmap, 2 ipsum, 3 opsum).
interface pe_id_scan_loader_if #(
  parameter int XID_W = 5,
  parameter int YID_W = 3
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_net;
  logic             cfg_set_yid;
  logic             cfg_set_xid;
  logic [YID_W-1:0] cfg_yid;
  logic [XID_W-1:0] cfg_xid;

  modport master (
    output cfg_valid, cfg_net, cfg_set_yid, cfg_set_xid, cfg_yid, cfg_xid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_net, cfg_set_yid, cfg_set_xid, cfg_yid, cfg_xid,
    output cfg_ready
  );
endinterface

// File: rtl/pe_id_scan_loader.sv
// pe_id_scan_loader: snapshots the PE-array ID generator outputs on start and
// shifts them into the GIN/GON multicast-controller ID scan chains, network by
// network, YIDs (ROWS-1..0) then XIDs (ROWS*COLS-1..0), so chain position 0
// ends up holding element 0.
// Optional build macro ID_LOADER_STALL_CNT_EN adds a 16-bit saturating count
// of cycles where a beat was offered but not accepted.
//
// state     | meaning
// S_IDLE    | waiting for start
// S_SHIFT_Y | offering YID beats of the current network
// S_SHIFT_X | offering XID beats of the current network
// S_DONE    | one-cycle done pulse, ln_config updated
module pe_id_scan_loader #(
  parameter int ROWS  = 6,
  parameter int COLS  = 8,
  parameter int XID_W = 5,
  parameter int YID_W = 3,
  parameter int LN_W  = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ROWS*COLS*XID_W-1:0]  filter_xid_flat,
  input  logic [ROWS*YID_W-1:0]       filter_yid_flat,
  input  logic [ROWS*COLS*XID_W-1:0]  ifmap_xid_flat,
  input  logic [ROWS*YID_W-1:0]       ifmap_yid_flat,
  input  logic [ROWS*COLS*XID_W-1:0]  ipsum_xid_flat,
  input  logic [ROWS*YID_W-1:0]       ipsum_yid_flat,
  input  logic [ROWS*COLS*XID_W-1:0]  opsum_xid_flat,
  input  logic [ROWS*YID_W-1:0]       opsum_yid_flat,
  input  logic [LN_W-1:0]             ln_config_in,
  pe_id_scan_loader_if.master         cfg,
  output logic                        busy,
  output logic                        done,
  output logic [LN_W-1:0]             ln_config
`ifdef ID_LOADER_STALL_CNT_EN
  ,
  output logic [15:0]                 stall_cnt
`endif
);

  localparam int NX    = ROWS * COLS;
  localparam int XW    = NX * XID_W;
  localparam int YW    = ROWS * YID_W;
  localparam int IDX_W = $clog2(NX);
  localparam logic [IDX_W-1:0] IDX_Y_LAST = IDX_W'(ROWS - 1);
  localparam logic [IDX_W-1:0] IDX_X_LAST = IDX_W'(NX - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SHIFT_Y = 2'd1,
    S_SHIFT_X = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           net_q, net_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [3:0][XW-1:0]   xid_snap_q, xid_snap_d;
  logic [3:0][YW-1:0]   yid_snap_q, yid_snap_d;
  logic [LN_W-1:0]      ln_snap_q, ln_snap_d;

  logic                 cfg_valid_q, cfg_valid_d;
  logic [1:0]           cfg_net_q, cfg_net_d;
  logic                 cfg_set_yid_q, cfg_set_yid_d;
  logic                 cfg_set_xid_q, cfg_set_xid_d;
  logic [YID_W-1:0]     cfg_yid_q, cfg_yid_d;
  logic [XID_W-1:0]     cfg_xid_q, cfg_xid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [LN_W-1:0]      ln_config_q, ln_config_d;

  logic                 accept;

  // Valid only exists in the shift states, so a handshake is valid & ready.
  assign accept = cfg_valid_q & cfg.cfg_ready;

  // Next-state, snapshot and index sequencing.
  always_comb begin
    state_d    = state_q;
    net_d      = net_q;
    idx_d      = idx_q;
    xid_snap_d = xid_snap_q;
    yid_snap_d = yid_snap_q;
    ln_snap_d  = ln_snap_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_SHIFT_Y;
          net_d      = 2'd0;
          idx_d      = IDX_Y_LAST;
          xid_snap_d = {opsum_xid_flat, ipsum_xid_flat, ifmap_xid_flat, filter_xid_flat};
          yid_snap_d = {opsum_yid_flat, ipsum_yid_flat, ifmap_yid_flat, filter_yid_flat};
          ln_snap_d  = ln_config_in;
        end
      end
      S_SHIFT_Y: begin
        if (accept) begin
          if (idx_q == '0) begin
            state_d = S_SHIFT_X;
            idx_d   = IDX_X_LAST;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end
      S_SHIFT_X: begin
        if (accept) begin
          if (idx_q != '0) begin
            idx_d = idx_q - 1'b1;
          end else if (net_q == 2'd3) begin
            state_d = S_DONE;
            idx_d   = '0;
          end else begin
            state_d = S_SHIFT_Y;
            net_d   = net_q + 2'd1;
            idx_d   = IDX_Y_LAST;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered output values derived from the next state, so the beat shown
  // after each edge always matches the state/index just entered.
  always_comb begin
    cfg_valid_d   = (state_d == S_SHIFT_Y) || (state_d == S_SHIFT_X);
    cfg_set_yid_d = (state_d == S_SHIFT_Y);
    cfg_set_xid_d = (state_d == S_SHIFT_X);
    cfg_net_d     = cfg_valid_d ? net_d : 2'd0;
    cfg_yid_d     = '0;
    cfg_xid_d     = '0;
    if (cfg_set_yid_d) cfg_yid_d = yid_snap_d[net_d][idx_d*YID_W +: YID_W];
    if (cfg_set_xid_d) cfg_xid_d = xid_snap_d[net_d][idx_d*XID_W +: XID_W];
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
    ln_config_d   = (state_d == S_DONE) ? ln_snap_d : ln_config_q;
  end

  // FSM, snapshot and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      net_q         <= '0;
      idx_q         <= '0;
      xid_snap_q    <= '0;
      yid_snap_q    <= '0;
      ln_snap_q     <= '0;
      cfg_valid_q   <= 1'b0;
      cfg_net_q     <= '0;
      cfg_set_yid_q <= 1'b0;
      cfg_set_xid_q <= 1'b0;
      cfg_yid_q     <= '0;
      cfg_xid_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ln_config_q   <= '0;
    end else begin
      state_q       <= state_d;
      net_q         <= net_d;
      idx_q         <= idx_d;
      xid_snap_q    <= xid_snap_d;
      yid_snap_q    <= yid_snap_d;
      ln_snap_q     <= ln_snap_d;
      cfg_valid_q   <= cfg_valid_d;
      cfg_net_q     <= cfg_net_d;
      cfg_set_yid_q <= cfg_set_yid_d;
      cfg_set_xid_q <= cfg_set_xid_d;
      cfg_yid_q     <= cfg_yid_d;
      cfg_xid_q     <= cfg_xid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      ln_config_q   <= ln_config_d;
    end
  end

  assign cfg.cfg_valid   = cfg_valid_q;
  assign cfg.cfg_net     = cfg_net_q;
  assign cfg.cfg_set_yid = cfg_set_yid_q;
  assign cfg.cfg_set_xid = cfg_set_xid_q;
  assign cfg.cfg_yid     = cfg_yid_q;
  assign cfg.cfg_xid     = cfg_xid_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign ln_config       = ln_config_q;

`ifdef ID_LOADER_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Stall counter: restarts with each accepted start, saturates, holds after done.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == S_IDLE && start) begin
      stall_cnt_d = '0;
    end else if (cfg_valid_q && !cfg.cfg_ready && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pe_id_scan_loader.sv
// Bench for pe_id_scan_loader: scoreboard of expected beats built from the
// driven ID inputs, compared as the DUT offers each beat.
module tb_pe_id_scan_loader;
  localparam int ROWS  = 6;
  localparam int COLS  = 8;
  localparam int XID_W = 5;
  localparam int YID_W = 3;
  localparam int LN_W  = 5;
  localparam int NX    = ROWS * COLS;
  localparam int NB    = 4 * (ROWS + NX);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [3:0][NX*XID_W-1:0] xid_flat;
  logic [3:0][ROWS*YID_W-1:0] yid_flat;
  logic [LN_W-1:0] ln_in;
  logic busy, done;
  logic [LN_W-1:0] ln_config;
`ifdef ID_LOADER_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  pe_id_scan_loader_if #(.XID_W(XID_W), .YID_W(YID_W)) cfg_if ();

  pe_id_scan_loader #(
    .ROWS(ROWS), .COLS(COLS), .XID_W(XID_W), .YID_W(YID_W), .LN_W(LN_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .filter_xid_flat (xid_flat[0]),
    .filter_yid_flat (yid_flat[0]),
    .ifmap_xid_flat  (xid_flat[1]),
    .ifmap_yid_flat  (yid_flat[1]),
    .ipsum_xid_flat  (xid_flat[2]),
    .ipsum_yid_flat  (yid_flat[2]),
    .opsum_xid_flat  (xid_flat[3]),
    .opsum_yid_flat  (yid_flat[3]),
    .ln_config_in    (ln_in),
    .cfg             (cfg_if),
    .busy            (busy),
    .done            (done),
    .ln_config       (ln_config)
`ifdef ID_LOADER_STALL_CNT_EN
    ,
    .stall_cnt       (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  logic [11:0] sb[$];
  logic [LN_W-1:0] exp_ln = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] cur_beat();
    return {cfg_if.cfg_net, cfg_if.cfg_set_yid, cfg_if.cfg_set_xid, cfg_if.cfg_yid, cfg_if.cfg_xid};
  endfunction

  // Beat monitor: every offered beat must equal the scoreboard head (held
  // stable while not accepted); idle cycles must show quiet lines.
  always @(negedge clk) begin
    if (!rst) begin
      if (cfg_if.cfg_valid) begin
        if (sb.size() == 0) chk("beat_unexpected_sb_size", 32'(sb.size()), 32'd1);
        else begin
          chk("beat", 32'(cur_beat()), 32'(sb[0]));
          if (cfg_if.cfg_ready) void'(sb.pop_front());
        end
      end else begin
        chk("idle_lines", 32'(cur_beat()), 32'd0);
      end
      if (done) done_cnt++;
    end
  end

  task automatic fill_random();
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < NX; i++) xid_flat[n][i*XID_W +: XID_W] = XID_W'($urandom_range(0, 31));
      for (int r = 0; r < ROWS; r++) yid_flat[n][r*YID_W +: YID_W] = YID_W'($urandom_range(0, 7));
    end
    ln_in = LN_W'($urandom_range(0, 31));
  endtask

  task automatic push_expected();
    for (int n = 0; n < 4; n++) begin
      for (int r = ROWS - 1; r >= 0; r--)
        sb.push_back({2'(n), 2'b10, yid_flat[n][r*YID_W +: YID_W], 5'd0});
      for (int i = NX - 1; i >= 0; i--)
        sb.push_back({2'(n), 2'b01, 3'd0, xid_flat[n][i*XID_W +: XID_W]});
    end
    exp_ln = ln_in;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // mode 0: ready=1; 1: toggle; 2: ten stall cycles; 3: re-start + input change at cycle 50
  task automatic run_load(input int mode, input int budget);
    int c;
    int d0;
    d0 = done_cnt;
    c = 0;
    while (done_cnt == d0 && c < budget) begin
      @(posedge clk); #1;
      c++;
      case (mode)
        1: cfg_if.cfg_ready = ~cfg_if.cfg_ready;
        2: cfg_if.cfg_ready = !(c >= 20 && c < 30);
        3: begin
          cfg_if.cfg_ready = 1'b1;
          if (c == 50) begin start = 1'b1; fill_random(); end
          if (c == 51) start = 1'b0;
        end
        default: cfg_if.cfg_ready = 1'b1;
      endcase
    end
    cfg_if.cfg_ready = 1'b1;
    start = 1'b0;
    chk("load_done_seen", 32'(done_cnt - d0), 32'd1);
    chk("busy_after_load", 32'(busy), 32'd0);
    chk("ln_config", 32'(ln_config), 32'(exp_ln));
    chk("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int d0;
    cfg_if.cfg_ready = 1'b1;
    xid_flat = '0;
    yid_flat = '0;
    ln_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(cfg_if.cfg_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ln", 32'(ln_config), 32'd0);
    rst = 1'b0;

    // Test 1: known pattern, ready tied high, cycle-exact timing.
    fill_random();
    for (int r = 0; r < ROWS; r++) yid_flat[0][r*YID_W +: YID_W] = YID_W'(r);
    for (int i = 0; i < NX; i++) xid_flat[0][i*XID_W +: XID_W] = XID_W'(i % 32);
    ln_in = 5'd19;
    d0 = done_cnt;
    push_expected();
    pulse_start();
    chk("first_beat", 32'(cur_beat()), 32'({2'd0, 2'b10, 3'd5, 5'd0}));
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      chk("valid_during_load", 32'(cfg_if.cfg_valid), 32'd1);
      if (k == 6) chk("beat7", 32'(cur_beat()), 32'({2'd0, 2'b01, 3'd0, 5'd15}));
      @(posedge clk);
    end
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_in_done", 32'(busy), 32'd1);
    chk("ln_in_done", 32'(ln_config), 32'd19);
    @(posedge clk);
    @(negedge clk);
    chk("done_low", 32'(done), 32'd0);
    chk("busy_low", 32'(busy), 32'd0);
    chk("sb_empty_t1", 32'(sb.size()), 32'd0);
    chk("done_count_t1", 32'(done_cnt - d0), 32'd1);

    // Test 2: ready toggling every cycle.
    fill_random();
    push_expected();
    pulse_start();
    run_load(1, 2000);

    // Test 3: start re-pulsed and inputs changed mid-load.
    fill_random();
    push_expected();
    d0 = done_cnt;
    pulse_start();
    run_load(3, 2000);
    repeat (20) @(posedge clk);
    #1;
    chk("one_done_t3", 32'(done_cnt - d0), 32'd1);
    chk("idle_after_t3", 32'(busy), 32'd0);

    // Test 4: async reset mid-load, then clean restart.
    fill_random();
    push_expected();
    pulse_start();
    repeat (100) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(cfg_if.cfg_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_ln", 32'(ln_config), 32'd0);
    chk("mid_rst_beat", 32'(cur_beat()), 32'd0);
    sb.delete();
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("no_done_after_rst", 32'(done_cnt - d0), 32'd0);
    chk("ln_kept_zero", 32'(ln_config), 32'd0);
    push_expected();
    pulse_start();
    chk("restart_first_beat", 32'(cur_beat()),
        32'({2'd0, 2'b10, yid_flat[0][(ROWS-1)*YID_W +: YID_W], 5'd0}));
    run_load(0, 2000);

    // Test 5: opsum IDs all unused values.
    fill_random();
    xid_flat[3] = '1;
    yid_flat[3] = '1;
    push_expected();
    pulse_start();
    run_load(0, 2000);

    // Test 6: ten stall cycles.
    fill_random();
    push_expected();
    pulse_start();
    run_load(2, 2000);
`ifdef ID_LOADER_STALL_CNT_EN
    chk("stall_cnt_after_done", 32'(stall_cnt), 32'd10);
    fill_random();
    push_expected();
    pulse_start();
    chk("stall_cnt_cleared", 32'(stall_cnt), 32'd0);
    run_load(0, 2000);
    chk("stall_cnt_no_stall", 32'(stall_cnt), 32'd0);
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
